smg_scan_module: RTL and testbench

Parametrised multi-digit 7-segment scan driver: holds DIGITS nibbles, encodes each to a segment pattern (decimal or hex glyph set), and time-multiplexes them onto one shared segment bus with a one-hot digit-select bus. New display data arrives through a load handshake and is double-buffered so that a frame is never torn. The block sits between the numeric datapath and the board's common-anode display pins, replacing the per-digit encoder plus external scan logic.

---
 rtl/smg_pkg.sv | 33 +++
 rtl/smg_glyph_lut.sv | 40 ++++
 rtl/smg_scan_module.sv | 189 ++++++++++++++++++
 tb/tb_smg_scan_module.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg
// Shared constants for the 7-segment scan driver: glyph patterns for digits,
// dash, blank and hex letters, plus the decimal-point bit position.
// Patterns are active-low in {dp,g,f,e,d,c,b,a} order with dp left dark.
package smg_pkg;

   typedef enum logic {
      GLYPH_DEC = 1'b0,
      GLYPH_HEX = 1'b1
   } glyph_set_e;

   localparam int DP_BIT = 7;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_HEX_A = 8'h88;
   localparam logic [7:0] SEG_HEX_B = 8'h83;
   localparam logic [7:0] SEG_HEX_C = 8'hC6;
   localparam logic [7:0] SEG_HEX_D = 8'hA1;
   localparam logic [7:0] SEG_HEX_E = 8'h86;
   localparam logic [7:0] SEG_HEX_F = 8'h8E;

endpackage

// File: rtl/smg_glyph_lut.sv
// smg_glyph_lut
// Combinational nibble to 7-segment pattern (active-low, dp dark).
// Ports:
//   i_nibble   [3:0]  value to display
//   i_hex_mode        glyph set: GLYPH_DEC (10 = dash, 11..15 blank) or GLYPH_HEX
//   o_seg      [7:0]  {dp,g,f,e,d,c,b,a}
module smg_glyph_lut
   import smg_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  glyph_set_e i_hex_mode,
   output logic [7:0] o_seg
);

   logic w_hex;
   assign w_hex = (i_hex_mode == GLYPH_HEX);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nibble)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = w_hex ? SEG_HEX_A : SEG_DASH;
         4'hB: o_seg = w_hex ? SEG_HEX_B : SEG_BLANK;
         4'hC: o_seg = w_hex ? SEG_HEX_C : SEG_BLANK;
         4'hD: o_seg = w_hex ? SEG_HEX_D : SEG_BLANK;
         4'hE: o_seg = w_hex ? SEG_HEX_E : SEG_BLANK;
         4'hF: o_seg = w_hex ? SEG_HEX_F : SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/smg_scan_module.sv
// smg_scan_module
// Multi-digit 7-segment scan driver with double-buffered display data.
// A load strobe captures new data into a shadow register; the shadow is
// copied to the active register only at a frame boundary so a frame is never
// torn. Each digit dwell starts with a dead window where everything is dark.
// Ports:
//   CLK, RSTn                 clock, async active-low reset
//   Number_Data [4*DIGITS]    digit nibbles, [3:0] = digit 0
//   DP_Mask, Blank_Mask       per-digit decimal point / force blank
//   Lz_En                     leading-zero suppression (captured with load)
//   Load_Req / Load_Ack       load strobe and its one-cycle acknowledge
//   Update_Done               pulses when shadow is copied to active
//   SMG_Data [7:0]            segment bus {dp,g,f,e,d,c,b,a}
//   Scan_Sig [DIGITS]         digit select, active-low one-hot
module smg_scan_module
   import smg_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int DEAD_CYCLES    = 4,
   parameter int HEX_MODE       = 0,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [4*DIGITS-1:0]   Number_Data,
   input  logic [DIGITS-1:0]     DP_Mask,
   input  logic [DIGITS-1:0]     Blank_Mask,
   input  logic                  Lz_En,
   input  logic                  Load_Req,
   output logic                  Load_Ack,
   output logic                  Update_Done,
   output logic [7:0]            SMG_Data,
   output logic [DIGITS-1:0]     Scan_Sig
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [7:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
   localparam glyph_set_e       GLYPH_SET = (HEX_MODE != 0) ? GLYPH_HEX : GLYPH_DEC;

   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;

   logic [4*DIGITS-1:0] r_sh_num;
   logic [DIGITS-1:0]   r_sh_dp;
   logic [DIGITS-1:0]   r_sh_blank;
   logic                r_sh_lz;
   logic [4*DIGITS-1:0] r_act_num;
   logic [DIGITS-1:0]   r_act_dp;
   logic [DIGITS-1:0]   r_act_blank;
   logic                r_act_lz;
   logic                r_pending;
   // Held low from reset until the first frame swap so an unloaded display
   // keeps every digit deselected.
   logic                r_disp_en;

   logic                r_load_ack;
   logic                r_update_done;
   logic [7:0]          r_smg;
   logic [DIGITS-1:0]   r_scan;

   logic                w_boundary;
   logic [3:0]          w_nib;
   logic                w_dp;
   logic                w_blank;
   logic                w_lz_hit;
   logic                w_zero_run;
   logic [DIGITS-1:0]   w_scan;
   logic [7:0]          w_glyph;
   logic [7:0]          w_seg;
   logic                w_dead;
   logic [7:0]          w_seg_pins;
   logic [DIGITS-1:0]   w_scan_pins;

   assign w_boundary = (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // A load on the boundary cycle lands in the shadow after the swap has
   // already sampled the old shadow, so it stays pending for the next frame.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_sh_num      <= '0;
         r_sh_dp       <= '0;
         r_sh_blank    <= '1;
         r_sh_lz       <= 1'b0;
         r_act_num     <= '0;
         r_act_dp      <= '0;
         r_act_blank   <= '1;
         r_act_lz      <= 1'b0;
         r_pending     <= 1'b0;
         r_disp_en     <= 1'b0;
         r_load_ack    <= 1'b0;
         r_update_done <= 1'b0;
      end else begin
         if (Load_Req) begin
            r_sh_num   <= Number_Data;
            r_sh_dp    <= DP_Mask;
            r_sh_blank <= Blank_Mask;
            r_sh_lz    <= Lz_En;
         end
         if (w_boundary && r_pending) begin
            r_act_num   <= r_sh_num;
            r_act_dp    <= r_sh_dp;
            r_act_blank <= r_sh_blank;
            r_act_lz    <= r_sh_lz;
            r_disp_en   <= 1'b1;
         end
         r_pending     <= Load_Req || (r_pending && !w_boundary);
         r_load_ack    <= Load_Req;
         r_update_done <= w_boundary && r_pending;
      end
   end

   // Walk from the top digit down; the zero run stays true only while every
   // digit so far is zero, which is exactly the leading-zero set.
   always_comb begin
      w_nib      = '0;
      w_dp       = 1'b0;
      w_blank    = 1'b0;
      w_lz_hit   = 1'b0;
      w_scan     = '1;
      w_zero_run = r_act_lz;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_act_num[4*i +: 4] == 4'h0);
         if (r_idx == IDX_W'(i)) begin
            w_nib     = r_act_num[4*i +: 4];
            w_dp      = r_act_dp[i];
            w_blank   = r_act_blank[i];
            w_lz_hit  = w_zero_run && (i != 0);
            w_scan[i] = 1'b0;
         end
      end
   end

   smg_glyph_lut u_lut (
      .i_nibble   (w_nib),
      .i_hex_mode (GLYPH_SET),
      .o_seg      (w_glyph)
   );

   always_comb begin
      w_seg = w_glyph;
      if (w_blank || w_lz_hit) begin
         w_seg = SEG_BLANK;
      end
      if (w_dp) begin
         w_seg[DP_BIT] = 1'b0;
      end
      w_dead      = (int'(r_cnt) < DEAD_CYCLES) || !r_disp_en;
      w_scan_pins = w_dead ? '1 : w_scan;
      w_seg_pins  = w_dead ? SEG_BLANK : w_seg;
      if (SEG_ACTIVE_LOW == 0) begin
         w_seg_pins = ~w_seg_pins;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_smg  <= SEG_OFF;
         r_scan <= '1;
      end else begin
         r_smg  <= w_seg_pins;
         r_scan <= w_scan_pins;
      end
   end

   assign Load_Ack    = r_load_ack;
   assign Update_Done = r_update_done;
   assign SMG_Data    = r_smg;
   assign Scan_Sig    = r_scan;

endmodule

// File: tb/tb_smg_scan_module.sv
// tb_smg_scan_module
// Three instances share stimulus: decimal glyphs, hex glyphs, and decimal
// with inverted segment polarity. DIGITS=4, DIV=10, DEAD_CYCLES=2, so one
// frame is 40 cycles. cyc counts rising edges since reset release; at the
// falling edge after edge n the pins show phase n-1 of the frame.
module tb_smg_scan_module;

   logic        CLK;
   logic        RSTn;
   logic [15:0] Number_Data;
   logic [3:0]  DP_Mask;
   logic [3:0]  Blank_Mask;
   logic        Lz_En;
   logic        Load_Req;

   logic        ack_d, ack_h, ack_i;
   logic        ud_d, ud_h, ud_i;
   logic [7:0]  smg_d, smg_h, smg_i;
   logic [3:0]  scan_d, scan_h, scan_i;

   int total = 0;
   int bad   = 0;
   int cyc;
   int ud_cnt_d = 0;
   int ud_cnt_h = 0;

   smg_scan_module #(.DIGITS(4), .CLK_HZ(10), .SCAN_HZ(1), .DEAD_CYCLES(2),
                     .HEX_MODE(0), .SEG_ACTIVE_LOW(1)) dut_d (
      .CLK(CLK), .RSTn(RSTn), .Number_Data(Number_Data), .DP_Mask(DP_Mask),
      .Blank_Mask(Blank_Mask), .Lz_En(Lz_En), .Load_Req(Load_Req),
      .Load_Ack(ack_d), .Update_Done(ud_d), .SMG_Data(smg_d), .Scan_Sig(scan_d));

   smg_scan_module #(.DIGITS(4), .CLK_HZ(10), .SCAN_HZ(1), .DEAD_CYCLES(2),
                     .HEX_MODE(1), .SEG_ACTIVE_LOW(1)) dut_h (
      .CLK(CLK), .RSTn(RSTn), .Number_Data(Number_Data), .DP_Mask(DP_Mask),
      .Blank_Mask(Blank_Mask), .Lz_En(Lz_En), .Load_Req(Load_Req),
      .Load_Ack(ack_h), .Update_Done(ud_h), .SMG_Data(smg_h), .Scan_Sig(scan_h));

   smg_scan_module #(.DIGITS(4), .CLK_HZ(10), .SCAN_HZ(1), .DEAD_CYCLES(2),
                     .HEX_MODE(0), .SEG_ACTIVE_LOW(0)) dut_i (
      .CLK(CLK), .RSTn(RSTn), .Number_Data(Number_Data), .DP_Mask(DP_Mask),
      .Blank_Mask(Blank_Mask), .Lz_En(Lz_En), .Load_Req(Load_Req),
      .Load_Ack(ack_i), .Update_Done(ud_i), .SMG_Data(smg_i), .Scan_Sig(scan_i));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(negedge CLK) begin
      if (ud_d === 1'b1) ud_cnt_d <= ud_cnt_d + 1;
      if (ud_h === 1'b1) ud_cnt_h <= ud_cnt_h + 1;
   end

   typedef struct packed {
      logic [15:0]     num;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic            lz;
      logic [3:0][7:0] dec;   // expected per digit, [0] = digit 0
      logic [3:0][7:0] hex;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int n);
      int guard;
      guard = 0;
      if (cyc > n) begin
         total++;
         bad++;
         $display("FAIL wait_to: at cyc %0d already past %0d", cyc, n);
      end
      while (cyc < n && guard < 20000) begin
         @(negedge CLK);
         guard++;
      end
      if (cyc < n) begin
         total++;
         bad++;
         $display("FAIL wait_to timeout: cyc %0d target %0d", cyc, n);
      end
   endtask

   task automatic chk_out(input string name, input logic [7:0] e_dec,
                          input logic [7:0] e_hex, input logic [3:0] e_scan);
      chk({name, " dec seg"}, {24'h0, smg_d}, {24'h0, e_dec});
      chk({name, " hex seg"}, {24'h0, smg_h}, {24'h0, e_hex});
      chk({name, " inv seg"}, {24'h0, smg_i}, {24'h0, ~e_dec});
      chk({name, " dec scan"}, {28'h0, scan_d}, {28'h0, e_scan});
      chk({name, " hex scan"}, {28'h0, scan_h}, {28'h0, e_scan});
      chk({name, " inv scan"}, {28'h0, scan_i}, {28'h0, e_scan});
   endtask

   task automatic chk_ud(input string name, input logic e);
      chk({name, " ud dec"}, {31'h0, ud_d}, {31'h0, e});
      chk({name, " ud hex"}, {31'h0, ud_h}, {31'h0, e});
   endtask

   // Drives the strobe at the falling edge of cyc L (captured at edge L+1),
   // checks the ack at L+1, then scrambles the data inputs.
   task automatic load_at(input int L, input logic [15:0] n, input logic [3:0] dp,
                          input logic [3:0] bl, input logic lz);
      wait_to(L);
      Number_Data = n;
      DP_Mask     = dp;
      Blank_Mask  = bl;
      Lz_En       = lz;
      Load_Req    = 1'b1;
      wait_to(L + 1);
      chk("load ack dec", {31'h0, ack_d}, 32'h1);
      chk("load ack hex", {31'h0, ack_h}, 32'h1);
      Load_Req    = 1'b0;
      Number_Data = ~n;
      DP_Mask     = ~dp;
      Blank_Mask  = ~bl;
      Lz_En       = ~lz;
   endtask

   // Frame whose swap happened at edge B: dead cycles and both ends of each dwell.
   task automatic check_frame(input int B, input logic [3:0][7:0] dec,
                              input logic [3:0][7:0] hex);
      logic [3:0] e_scan;
      for (int d = 0; d < 4; d++) begin
         e_scan    = 4'hF;
         e_scan[d] = 1'b0;
         wait_to(B + d*10 + 1);
         chk_out("dead cnt0", 8'hFF, 8'hFF, 4'hF);
         wait_to(B + d*10 + 2);
         chk_out("dead cnt1", 8'hFF, 8'hFF, 4'hF);
         wait_to(B + d*10 + 3);
         chk_out("dwell first", dec[d], hex[d], e_scan);
         wait_to(B + d*10 + 10);
         chk_out("dwell last", dec[d], hex[d], e_scan);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int L;
      int B;
      int ud0;

      vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0,
                  {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{16'h00A7, 4'b0000, 4'b0000, 1'b1,
                  {8'hFF, 8'hFF, 8'hBF, 8'hF8}, {8'hFF, 8'hFF, 8'h88, 8'hF8}};
      vecs[2] = '{16'h0000, 4'b0100, 4'b0000, 1'b1,
                  {8'hFF, 8'h7F, 8'hFF, 8'hC0}, {8'hFF, 8'h7F, 8'hFF, 8'hC0}};
      vecs[3] = '{16'hFEDC, 4'b0000, 4'b0000, 1'b0,
                  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'h8E, 8'h86, 8'hA1, 8'hC6}};
      vecs[4] = '{16'h5B08, 4'b0001, 4'b0010, 1'b1,
                  {8'h92, 8'hFF, 8'hFF, 8'h00}, {8'h92, 8'h83, 8'hFF, 8'h00}};
      vecs[5] = '{16'h0906, 4'b0000, 4'b0000, 1'b1,
                  {8'hFF, 8'h90, 8'hC0, 8'h82}, {8'hFF, 8'h90, 8'hC0, 8'h82}};
      vecs[6] = '{16'h1234, 4'b1010, 4'b1111, 1'b0,
                  {8'h7F, 8'hFF, 8'h7F, 8'hFF}, {8'h7F, 8'hFF, 8'h7F, 8'hFF}};

      RSTn        = 1'b0;
      Number_Data = 16'h0;
      DP_Mask     = 4'h0;
      Blank_Mask  = 4'h0;
      Lz_En       = 1'b0;
      Load_Req    = 1'b0;
      repeat (3) @(negedge CLK);
      chk_out("in reset", 8'hFF, 8'hFF, 4'hF);
      chk("in reset ack", {31'h0, ack_d}, 32'h0);
      chk_ud("in reset", 1'b0);
      RSTn = 1'b1;

      // Unloaded display stays dark for a whole frame.
      for (int n = 1; n <= 40; n++) begin
         wait_to(n);
         chk_out("post reset", 8'hFF, 8'hFF, 4'hF);
      end

      for (int i = 0; i < 7; i++) begin
         L = 45 + 80*i;
         B = L + 35;
         load_at(L, vecs[i].num, vecs[i].dp, vecs[i].blank, vecs[i].lz);
         wait_to(L + 2);
         chk("ack one cycle", {31'h0, ack_d}, 32'h0);
         wait_to(B - 1);
         chk_ud("before swap", 1'b0);
         wait_to(B);
         chk_ud("swap", 1'b1);
         check_frame(B, vecs[i].dec, vecs[i].hex);
      end

      // Two loads inside one frame: the last one wins.
      load_at(645, 16'h3333, 4'h0, 4'h0, 1'b0);
      load_at(655, 16'h4444, 4'h0, 4'h0, 1'b0);
      wait_to(680);
      chk_ud("last wins swap", 1'b1);
      wait_to(683);
      chk_out("last wins d0", 8'h99, 8'h99, 4'b1110);

      // Second load lands on the boundary edge itself.
      wait_to(721);
      ud0 = ud_cnt_d;
      load_at(725, 16'h1111, 4'h0, 4'h0, 1'b0);
      load_at(759, 16'h2222, 4'h0, 4'h0, 1'b0);
      chk_ud("boundary load swap1", 1'b1);
      wait_to(763);
      chk_out("boundary load frame1", 8'hF9, 8'hF9, 4'b1110);
      wait_to(800);
      chk_ud("boundary load swap2", 1'b1);
      wait_to(801);
      chk("boundary load ud count", ud_cnt_d - ud0, 2);
      wait_to(803);
      chk_out("boundary load frame2", 8'hA4, 8'hA4, 4'b1110);
      wait_to(840);
      chk_ud("no pending swap", 1'b0);

      // Reset mid-dwell with a load still pending.
      load_at(845, 16'h5555, 4'h0, 4'h0, 1'b0);
      wait_to(855);
      chk_out("pre reset d1", 8'hA4, 8'hA4, 4'b1101);
      #2 RSTn = 1'b0;
      #1;
      chk_out("async reset", 8'hFF, 8'hFF, 4'hF);
      chk("async reset ack", {31'h0, ack_d}, 32'h0);
      @(negedge CLK);
      RSTn = 1'b1;
      ud0 = ud_cnt_h;
      for (int n = 1; n <= 80; n++) begin
         wait_to(n);
         chk_out("after reset blank", 8'hFF, 8'hFF, 4'hF);
      end
      chk("after reset no update", ud_cnt_h - ud0, 0);

      load_at(85, vecs[0].num, vecs[0].dp, vecs[0].blank, vecs[0].lz);
      wait_to(120);
      chk_ud("reload swap", 1'b1);
      check_frame(120, vecs[0].dec, vecs[0].hex);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
